gen_syn_filt: RTL and testbench



---
 rtl/gen_syn_filt.sv | 79 +++++++
 tb/tb_gen_syn_filt.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gen_syn_filt.sv
// Multi-channel level synchroniser with a per-channel glitch filter and
// registered rise/fall pulses. One lane instance per channel.

module gen_syn_filt_lane #(
  parameter int   STAGE   = 2,
  parameter int   FILT    = 3,
  parameter logic RST_BIT = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [STAGE-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             sync_out;
  logic             upd;

  assign sync_out = sr[STAGE-1];
  // Accept only after FILT consecutive samples that disagree with q.
  assign upd      = (sync_out != q) && (cnt == CW'(FILT-1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr   <= {STAGE{RST_BIT}};
      cnt  <= '0;
      q    <= RST_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sr   <= {sr[STAGE-2:0], d};
      rise <= upd &  sync_out;
      fall <= upd & ~sync_out;
      if (sync_out == q || upd) cnt <= '0;
      else                      cnt <= cnt + CW'(1);
      if (upd) q <= sync_out;
    end
  end
endmodule

module gen_syn_filt #(
  parameter int            CH      = 4,
  parameter int            STAGE   = 2,
  parameter int            FILT    = 3,
  parameter logic [CH-1:0] RST_VAL = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [CH-1:0] data_asyn,
  output logic [CH-1:0] data_syn,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          any_edge
);
  if (CH < 1 || STAGE < 2 || FILT < 1) begin : g_bad_param
    $error("gen_syn_filt: need CH>=1, STAGE>=2, FILT>=1");
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    gen_syn_filt_lane #(
      .STAGE  (STAGE),
      .FILT   (FILT),
      .RST_BIT(RST_VAL[i])
    ) u_lane (
      .CLK (CLK),
      .RST (RST),
      .d   (data_asyn[i]),
      .q   (data_syn[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end

  assign any_edge = |(rise | fall);
endmodule

// File: tb/tb_gen_syn_filt.sv
// Bench for gen_syn_filt: default instance plus STAGE=3/FILT=1/RST_VAL=F
// instance, per-cycle scoreboard from a sample-window model, table + corners.

module tb_gen_syn_filt;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] data_asyn = 4'h0;
  logic [3:0] syn1, rise1, fall1, syn2, rise2, fall2;
  logic       any1, any2;

  always #5 CLK = ~CLK;

  gen_syn_filt u_dut1 (
    .CLK(CLK), .RST(RST), .data_asyn(data_asyn),
    .data_syn(syn1), .rise(rise1), .fall(fall1), .any_edge(any1)
  );

  gen_syn_filt #(.CH(4), .STAGE(3), .FILT(1), .RST_VAL(4'hF)) u_dut2 (
    .CLK(CLK), .RST(RST), .data_asyn(data_asyn),
    .data_syn(syn2), .rise(rise2), .fall(fall2), .any_edge(any2)
  );

  typedef struct packed {
    logic [3:0] syn;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } out_t;

  typedef struct {
    logic [3:0] din;
    int         ncyc;
    logic [3:0] exp1;
    logic [3:0] exp2;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  out_t q1[$];
  out_t q2[$];
  logic [3:0] hist[0:4095];
  int   n = 0;
  logic [3:0] f1 = 4'h0;
  logic [3:0] f2 = 4'hF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Filter moves to the opposite level once the last FILT synchronised
  // samples (input delayed STAGE edges) all disagree with it.
  function automatic out_t model(input int stage, input int filt,
                                 input logic [3:0] rv, inout logic [3:0] flt);
    out_t       o;
    logic [3:0] w;
    logic       upd;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      upd = 1'b1;
      for (int j = 0; j < filt; j++) begin
        int idx;
        idx = n - stage - j;
        w = (idx < 0) ? rv : hist[idx];
        if (w[c] == flt[c]) upd = 1'b0;
      end
      if (upd) begin
        o.rise[c] = ~flt[c];
        o.fall[c] =  flt[c];
        flt[c]    = ~flt[c];
      end
    end
    o.syn = flt;
    o.any = |(o.rise | o.fall);
    return o;
  endfunction

  task automatic step(input logic [3:0] d);
    out_t e;
    @(negedge CLK);
    data_asyn = d;
    hist[n]   = d;
    q1.push_back(model(2, 3, 4'h0, f1));
    q2.push_back(model(3, 1, 4'hF, f2));
    n++;
    @(posedge CLK);
    #1;
    e = q1.pop_front();
    chk("sb_dut1", 32'({syn1, rise1, fall1, any1}), 32'(e));
    e = q2.pop_front();
    chk("sb_dut2", 32'({syn2, rise2, fall2, any2}), 32'(e));
  endtask

  // Assert RST between edges, check immediate clear and hold through an edge.
  task automatic do_rst(input logic [3:0] d);
    @(negedge CLK);
    data_asyn = d;
    #2;
    RST = 1'b1;
    #1;
    chk("rst_async_dut1", 32'({syn1, rise1, fall1, any1}), 32'({4'h0, 4'h0, 4'h0, 1'b0}));
    chk("rst_async_dut2", 32'({syn2, rise2, fall2, any2}), 32'({4'hF, 4'h0, 4'h0, 1'b0}));
    @(posedge CLK);
    #1;
    chk("rst_hold_dut1", 32'({syn1, rise1, fall1, any1}), 32'({4'h0, 4'h0, 4'h0, 1'b0}));
    chk("rst_hold_dut2", 32'({syn2, rise2, fall2, any2}), 32'({4'hF, 4'h0, 4'h0, 1'b0}));
    RST = 1'b0;
    n  = 0;
    f1 = 4'h0;
    f2 = 4'hF;
    q1.delete();
    q2.delete();
  endtask

  initial begin
    vec_t vt[8];
    int   lat1, lat2, rcnt, fcnt, acnt, kr, kf, hi1, hi2;
    logic f2seen;

    vt[0] = '{4'h1, 6, 4'h1, 4'h1};
    vt[1] = '{4'h3, 2, 4'h1, 4'h1};
    vt[2] = '{4'h1, 6, 4'h1, 4'h1};
    vt[3] = '{4'h3, 3, 4'h1, 4'h1};
    vt[4] = '{4'h1, 6, 4'h1, 4'h1};
    vt[5] = '{4'hA, 6, 4'hA, 4'hA};
    vt[6] = '{4'h5, 6, 4'h5, 4'h5};
    vt[7] = '{4'h0, 6, 4'h0, 4'h0};

    repeat (2) @(posedge CLK);
    do_rst(4'hF);

    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < vt[v].ncyc; k++) step(vt[v].din);
      chk("vec_end_dut1", 32'(syn1), 32'(vt[v].exp1));
      chk("vec_end_dut2", 32'(syn2), 32'(vt[v].exp2));
    end

    // Latency from reset release: 5 edges default, 4 edges for STAGE=3/FILT=1.
    for (int k = 0; k < 6; k++) step(4'hF);
    do_rst(4'hF);
    lat1 = -1; lat2 = -1; rcnt = 0; fcnt = 0; acnt = 0; f2seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(4'h1);
      if (syn1[0] && lat1 < 0) lat1 = k + 1;
      if (!syn2[3] && lat2 < 0) begin
        lat2   = k + 1;
        f2seen = fall2[3];
      end
      rcnt += int'(rise1[0]);
      fcnt += int'(|fall1);
      acnt += int'(any1);
    end
    chk("latency_dut1", 32'(lat1), 32'd5);
    chk("rise_once", 32'(rcnt), 32'd1);
    chk("no_fall", 32'(fcnt), 32'd0);
    chk("any_once", 32'(acnt), 32'd1);
    chk("latency_dut2", 32'(lat2), 32'd4);
    chk("fall2_ch3", 32'(f2seen), 32'd1);

    // 3-sample pulse on ch1 is accepted; rise and fall 3 cycles apart.
    kr = -1; kf = -1;
    for (int k = 0; k < 11; k++) begin
      step(k < 3 ? 4'h3 : 4'h1);
      if (rise1[1]) kr = k;
      if (fall1[1]) kf = k;
    end
    chk("pulse_rise_seen", 32'(kr >= 0), 32'd1);
    chk("pulse_spacing", 32'(kf - kr), 32'd3);

    // 2-sample glitch rejected by default filter, passed by FILT=1.
    hi1 = 0; hi2 = 0; acnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(k < 2 ? 4'h3 : 4'h1);
      hi1 += int'(syn1[1]);
      hi2 += int'(syn2[1]);
      acnt += int'(any1);
    end
    chk("glitch2_dut1", 32'(hi1), 32'd0);
    chk("glitch2_no_edge", 32'(acnt), 32'd0);
    chk("glitch2_dut2", 32'(hi2), 32'd2);

    hi1 = 0; hi2 = 0;
    for (int k = 0; k < 8; k++) begin
      step(k < 1 ? 4'h5 : 4'h1);
      hi1 += int'(syn1[2]);
      hi2 += int'(syn2[2]);
    end
    chk("glitch1_dut1", 32'(hi1), 32'd0);
    chk("glitch1_dut2", 32'(hi2), 32'd1);

    // Simultaneous multi-channel updates.
    do_rst(4'h0);
    kr = -1; acnt = 0;
    for (int k = 0; k < 7; k++) begin
      step(4'hA);
      if (rise1 == 4'hA) kr = k;
      acnt += int'(any1);
    end
    chk("multi_rise_A", 32'(kr), 32'd4);
    chk("multi_any_once", 32'(acnt), 32'd1);
    kf = 0;
    for (int k = 0; k < 7; k++) begin
      step(4'h5);
      if (fall1 == 4'hA) kf = {28'd0, rise1};
    end
    chk("multi_swap_rise", 32'(kf), 32'h5);

    // Reset with ch2 counter partway; held input re-qualifies from scratch.
    do_rst(4'h0);
    for (int k = 0; k < 4; k++) step(4'h4);
    do_rst(4'h4);
    lat1 = -1; rcnt = 0;
    for (int k = 0; k < 7; k++) begin
      step(4'h4);
      if (syn1[2] && lat1 < 0) lat1 = k + 1;
      rcnt += int'(rise1[2]);
    end
    chk("rst_midfilt_latency", 32'(lat1), 32'd5);
    chk("rst_midfilt_rise", 32'(rcnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
